// File: rtl/rv_pkg.sv
// Shared RV32I datapath constants used by the integer register file.
package rv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = 5;
    localparam int ZERO_REG  = 0;

endpackage

// File: rtl/reg_file_regn.sv
// One storage entry: WIDTH-bit register with load enable, async active-low clear.
module regn #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on load; clear to zero whenever reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Multi-port integer register file with entry 0 tied to zero, optional
// write-to-read bypass and a per-entry pending scoreboard for decode stalls.
module reg_file
    import rv_pkg::*;
#(
    parameter  int WIDTH  = XLEN,
    parameter  int DEPTH  = REG_DEPTH,
    parameter  int N_READ = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
    input  logic [N_READ*AW-1:0]    ra,
    output logic [N_READ*WIDTH-1:0] rd,
    output logic [N_READ-1:0]       rd_busy,
    output logic [AW:0]             busy_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [DEPTH-1:0][WIDTH-1:0] ent;
    logic [DEPTH-1:0]            pend_r;
    logic [DEPTH-1:0]            pend_nxt;
    logic [AW:0]                 cnt_nxt;

    // Number of set bits in the pending vector.
    function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign ent[0] = '0;

    // Storage entries 1..DEPTH-1; entry 0 has no flops.
    for (genvar i = 1; i < DEPTH; i++) begin : g_ent
        regn #(.WIDTH(WIDTH)) u_regn (
            .clk   (clk),
            .rst_n (rst),
            .load  (we && (waddr == AW'(i))),
            .d     (wdata),
            .q     (ent[i])
        );
    end

    // Next pending vector: a write retires its entry, a reserve marks it;
    // the reserve is applied last so a new producer overrides the retiring one.
    always_comb begin
        pend_nxt = pend_r;
        if (we && (waddr != ZERO_ADDR)) begin
            pend_nxt[waddr] = 1'b0;
        end else begin
            pend_nxt = pend_nxt;
        end
        if (rsv_en && (rsv_addr != ZERO_ADDR)) begin
            pend_nxt[rsv_addr] = 1'b1;
        end else begin
            pend_nxt = pend_nxt;
        end
        pend_nxt[0] = 1'b0;
        cnt_nxt     = popcount(pend_nxt);
    end

    // Scoreboard and its population count advance together so they never disagree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r   <= '0;
            busy_cnt <= '0;
        end else begin
            pend_r   <= pend_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Per-port read mux with optional same-cycle forwarding of the write port.
    for (genvar k = 0; k < N_READ; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             busy;
        logic             wr_hit;
        logic             rsv_hit;

        assign addr = ra[k*AW +: AW];

        // Select data and busy for this port; reset forces both to zero.
        always_comb begin
            data    = '0;
            busy    = 1'b0;
            wr_hit  = (BYPASS != 0) && we && (waddr == addr);
            rsv_hit = rsv_en && (rsv_addr == addr);
            if (!rst) begin
                data = '0;
                busy = 1'b0;
            end else if (addr == ZERO_ADDR) begin
                data = '0;
                busy = 1'b0;
            end else if (wr_hit) begin
                data = wdata;
                busy = rsv_hit ? pend_r[addr] : 1'b0;
            end else begin
                data = ent[addr];
                busy = pend_r[addr];
            end
        end

        assign rd[k*WIDTH +: WIDTH] = data;
        assign rd_busy[k]           = busy;
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: two instances (bypass on / off) share
// stimulus and are compared against an array-based reference model.
module tb_reg_file;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [W-1:0]      wdata;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [NR*AW-1:0]  ra;
    logic [NR*W-1:0]   rd_b,   rd_n;
    logic [NR-1:0]     busy_b, busy_n;
    logic [AW:0]       cnt_b,  cnt_n;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] mem_m  [D];
    bit           pend_m [D];

    always #5 clk = ~clk;

    reg_file #(.WIDTH(W), .DEPTH(D), .N_READ(NR), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ra(ra),
        .rd(rd_b), .rd_busy(busy_b), .busy_cnt(cnt_b)
    );

    reg_file #(.WIDTH(W), .DEPTH(D), .N_READ(NR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ra(ra),
        .rd(rd_n), .rd_busy(busy_n), .busy_cnt(cnt_n)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (!rst || a == 0) return '0;
        if (byp && we && waddr == a) return wdata;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (!rst || a == 0) return 1'b0;
        if (byp && we && waddr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
        return pend_m[a];
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(pend_m[i]);
        return (AW+1)'(c);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            mem_m[i]  = '0;
            pend_m[i] = 1'b0;
        end
    endtask

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic tick();
        if (rst) begin
            if (we && waddr != 0) begin
                mem_m[waddr]  = wdata;
                pend_m[waddr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) pend_m[rsv_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; waddr = '0; rsv_addr = '0; wdata = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; idle(); ra = '0; model_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (rd_b !== '0 || busy_b !== '0 || cnt_b !== '0) begin
            n_err++;
            $display("FAIL reset_init: rd=%h busy=%b cnt=%0d required 0/0/0", rd_b, busy_b, cnt_b);
        end
        rst = 1'b1;
        tick();
        // populate entry 3 and reserve entry 6 so the reset has something to clear
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0055; rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        idle();
        // mid-cycle reset while a write to entry 3 is in flight
        we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF; ra = {5'd6, 5'd3};
        #3 rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (rd_b !== '0 || busy_b !== '0 || cnt_b !== '0) begin
            n_err++;
            $display("FAIL reset_mid: rd=%h busy=%b cnt=%0d required 0/0/0", rd_b, busy_b, cnt_b);
        end
        tick();
        n_vec++;
        if (rd_b !== '0 || cnt_b !== '0 || rd_n !== '0) begin
            n_err++;
            $display("FAIL reset_held: rd=%h rd_nb=%h cnt=%0d required 0", rd_b, rd_n, cnt_b);
        end
        idle();
        #2 rst = 1'b1;
        tick();
        n_vec++;
        if (rd_b[W-1:0] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_release_ra3: got %h required 00000000", rd_b[W-1:0]);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd1; wdata = 32'd5; tick();
        waddr = 5'd31; wdata = 32'hFFFF_FFFF; tick();
        idle(); ra = {5'd31, 5'd1}; #1;
        n_vec++;
        if (rd_b[W-1:0] !== 32'd5 || rd_n[W-1:0] !== 32'd5) begin
            n_err++;
            $display("FAIL wr_port0: got %h/%h required 00000005", rd_b[W-1:0], rd_n[W-1:0]);
        end
        n_vec++;
        if (rd_b[2*W-1:W] !== 32'hFFFF_FFFF || rd_n[2*W-1:W] !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wr_port1: got %h/%h required ffffffff", rd_b[2*W-1:W], rd_n[2*W-1:W]);
        end
        we = 1'b1; waddr = 5'd0; wdata = 32'd7; ra = {5'd0, 5'd0}; #1;
        n_vec++;
        if (rd_b !== '0) begin
            n_err++;
            $display("FAIL zero_bypass: got %h required 0", rd_b);
        end
        tick(); idle(); #1;
        n_vec++;
        if (rd_b[W-1:0] !== 32'd0 || rd_n[W-1:0] !== 32'd0) begin
            n_err++;
            $display("FAIL zero_read: got %h/%h required 00000000", rd_b[W-1:0], rd_n[W-1:0]);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd4; wdata = 32'h0000_AAAA; tick();
        we = 1'b1; waddr = 5'd4; wdata = 32'h0000_1234; ra = {5'd0, 5'd4}; #1;
        n_vec++;
        if (rd_b[W-1:0] !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL bypass_on: got %h required 00001234", rd_b[W-1:0]);
        end
        n_vec++;
        if (rd_n[W-1:0] !== 32'h0000_AAAA) begin
            n_err++;
            $display("FAIL bypass_off_old: got %h required 0000aaaa", rd_n[W-1:0]);
        end
        tick(); idle(); #1;
        n_vec++;
        if (rd_n[W-1:0] !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL bypass_off_new: got %h required 00001234", rd_n[W-1:0]);
        end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 5'd6; ra = {5'd0, 5'd6}; tick(); idle(); #1;
        n_vec++;
        if (busy_b[0] !== 1'b1 || busy_n[0] !== 1'b1 || cnt_b !== 6'd1 || cnt_n !== 6'd1) begin
            n_err++;
            $display("FAIL rsv6: busy=%b/%b cnt=%0d/%0d required 1/1 1/1", busy_b[0], busy_n[0], cnt_b, cnt_n);
        end
        we = 1'b1; waddr = 5'd6; wdata = 32'h0000_0066; #1;
        n_vec++;
        if (busy_b[0] !== 1'b0 || busy_n[0] !== 1'b1) begin
            n_err++;
            $display("FAIL clr_same_cycle: busy_byp=%b busy_nb=%b required 0 1", busy_b[0], busy_n[0]);
        end
        tick(); idle(); #1;
        n_vec++;
        if (cnt_b !== 6'd0 || cnt_n !== 6'd0 || busy_n[0] !== 1'b0) begin
            n_err++;
            $display("FAIL clr_next: cnt=%0d/%0d busy_nb=%b required 0 0 0", cnt_b, cnt_n, busy_n[0]);
        end
        rsv_en = 1'b1; rsv_addr = 5'd0; tick(); idle(); #1;
        n_vec++;
        if (cnt_b !== 6'd0) begin
            n_err++;
            $display("FAIL rsv_zero: cnt=%0d required 0", cnt_b);
        end
    endtask

    task automatic test_simultaneous();
        rsv_en = 1'b1; rsv_addr = 5'd9; tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_9999; ra = {5'd0, 5'd9}; #1;
        n_vec++;
        if (busy_b[0] !== 1'b1 || rd_b[W-1:0] !== 32'h0000_9999) begin
            n_err++;
            $display("FAIL simul_cycle: busy=%b rd=%h required 1 00009999", busy_b[0], rd_b[W-1:0]);
        end
        tick(); idle(); #1;
        n_vec++;
        if (busy_b[0] !== 1'b1 || rd_n[W-1:0] !== 32'h0000_9999 || cnt_b !== 6'd1) begin
            n_err++;
            $display("FAIL simul_after: busy=%b rd_nb=%h cnt=%0d required 1 00009999 1", busy_b[0], rd_n[W-1:0], cnt_b);
        end
        we = 1'b1; waddr = 5'd9; tick(); idle();
    endtask

    task automatic test_saturation();
        for (int i = 1; i < D; i++) begin
            rsv_en = 1'b1; rsv_addr = AW'(i); tick();
        end
        idle(); #1;
        n_vec++;
        if (cnt_b !== 6'd31 || cnt_n !== 6'd31 || exp_cnt() !== 6'd31) begin
            n_err++;
            $display("FAIL sat_full: cnt=%0d/%0d required 31", cnt_b, cnt_n);
        end
        for (int i = 1; i < D; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = $urandom; tick();
        end
        idle(); #1;
        n_vec++;
        if (cnt_b !== 6'd0 || cnt_n !== 6'd0) begin
            n_err++;
            $display("FAIL sat_empty: cnt=%0d/%0d required 0", cnt_b, cnt_n);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we       = ($urandom_range(0, 1) == 1);
            waddr    = AW'($urandom_range(0, D-1));
            wdata    = $urandom;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, D-1));
            ra       = {AW'($urandom_range(0, D-1)), AW'($urandom_range(0, D-1))};
            if (c % 5 == 0) ra[AW-1:0] = waddr;
            #1;
            for (int k = 0; k < NR; k++) begin
                n_vec++;
                if (rd_b[k*W +: W] !== exp_rd(ra[k*AW +: AW], 1'b1) ||
                    rd_n[k*W +: W] !== exp_rd(ra[k*AW +: AW], 1'b0)) begin
                    n_err++;
                    $display("FAIL rand_rd c=%0d k=%0d: got %h/%h required %h/%h", c, k,
                             rd_b[k*W +: W], rd_n[k*W +: W],
                             exp_rd(ra[k*AW +: AW], 1'b1), exp_rd(ra[k*AW +: AW], 1'b0));
                end
                n_vec++;
                if (busy_b[k] !== exp_busy(ra[k*AW +: AW], 1'b1) ||
                    busy_n[k] !== exp_busy(ra[k*AW +: AW], 1'b0)) begin
                    n_err++;
                    $display("FAIL rand_busy c=%0d k=%0d: got %b/%b required %b/%b", c, k,
                             busy_b[k], busy_n[k],
                             exp_busy(ra[k*AW +: AW], 1'b1), exp_busy(ra[k*AW +: AW], 1'b0));
                end
            end
            n_vec++;
            if (cnt_b !== exp_cnt() || cnt_n !== exp_cnt()) begin
                n_err++;
                $display("FAIL rand_cnt c=%0d: got %0d/%0d required %0d", c, cnt_b, cnt_n, exp_cnt());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
